ddr_axi_memtest_ctrl: RTL

- AXI4 master sequencer that drives the MIG DDR3 AXI slave port (30-bit address, 32-bit data, 4-bit ID) through a full write-then-readback memory test.
- Writes NUM_BURSTS INCR bursts of an address-derived pattern, reads them back and compares every beat.
- Reports pass/fail, error count and first failing address.
- Sits between board-level control (button/VIO/MicroBlaze GPIO) and the MIG instance, in the ui_clk domain.

---
 rtl/ddr_axi_memtest_ctrl_if.sv | 86 ++++++++
 rtl/ddr_axi_memtest_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_axi_memtest_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_axi_memtest_ctrl_if
//  Description : AXI4 bundle between the memory-test sequencer (master) and
//                the MIG DDR3 AXI slave port. Carries all five channels.
//  Ports       : none (signal bundle only)
//                master modport : drives AW/W/AR payload + valids, bready,
//                                 rready; receives readies and B/R payload
//                slave modport  : the mirror image
//  Revision    : 1.0 - initial release
// ============================================================================
interface ddr_axi_memtest_ctrl_if #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) ();
    // write address channel
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;
    // write data channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    // write response channel
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // read address channel
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic                    arvalid;
    logic                    arready;
    // read data channel
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/ddr_axi_memtest_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_axi_memtest_ctrl
//  Description : AXI4 master that runs a write-then-readback test over the
//                MIG DDR3 slave port. Writes NUM_BURSTS INCR bursts of the
//                pattern (byte address XOR seed), reads them back, compares
//                every beat and reports pass/fail, error count and the first
//                failing byte address.
//  Ports       : ui_clk              - MIG user clock (sole clock)
//                ui_clk_sync_rst     - synchronous active-high reset
//                init_calib_complete - MIG calibration done
//                start               - one-cycle pulse, begins a pass
//                seed                - pattern seed, sampled at start
//                m_axi               - AXI4 master bundle
//                busy/done/pass      - test status
//                err_count           - saturating error count
//                first_err_addr      - byte address of the first error
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_axi_memtest_ctrl #(
    parameter int                    ADDR_WIDTH = 30,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BURST_LEN  = 16,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
    parameter int                    NUM_BURSTS = 1024
) (
    input  wire logic                  ui_clk,
    input  wire logic                  ui_clk_sync_rst,
    input  wire logic                  init_calib_complete,
    input  wire logic                  start,
    input  wire logic [31:0]           seed,
    ddr_axi_memtest_ctrl_if.master     m_axi,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [15:0]                err_count,
    output logic [ADDR_WIDTH-1:0]      first_err_addr
);

    localparam int                    BCW         = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [BCW-1:0]        LAST_BURST  = BCW'(NUM_BURSTS - 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * 4);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_CAL = 3'd1,
        S_WR_ADDR  = 3'd2,
        S_WR_DATA  = 3'd3,
        S_WR_RESP  = 3'd4,
        S_RD_ADDR  = 3'd5,
        S_RD_DATA  = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [BCW-1:0]          burst_cnt;
    logic [7:0]              beat_cnt;
    logic [DATA_WIDTH-1:0]   seed_q;

    logic                    aw_valid;
    logic                    w_valid;
    logic                    w_last;
    logic                    b_ready;
    logic                    ar_valid;
    logic                    r_ready;

    logic [ADDR_WIDTH-1:0]   beat_addr;
    logic [DATA_WIDTH-1:0]   pattern;
    logic                    start_accept;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    ar_hs;
    logic                    r_hs;
    logic                    at_last_beat;
    logic                    at_last_burst;
    logic                    rd_bad;
    logic                    err_event;
    logic [ADDR_WIDTH-1:0]   err_addr;

    // IDs are fixed at zero, so returned IDs carry no information.
    logic                    unused_ids;
    assign unused_ids = ^{m_axi.bid, m_axi.rid};

    // ------------------------------------------------------------------
    // Beat address and expected pattern; both derive only from registers
    // that move on handshakes, so W payload is stable under backpressure.
    // ------------------------------------------------------------------
    assign beat_addr     = base_addr + ADDR_WIDTH'({beat_cnt, 2'b00});
    assign pattern       = DATA_WIDTH'(beat_addr) ^ seed_q;

    assign start_accept  = (state == S_IDLE) && start;
    assign aw_hs         = (state == S_WR_ADDR) && m_axi.awready;
    assign w_hs          = (state == S_WR_DATA) && m_axi.wready;
    assign b_hs          = (state == S_WR_RESP) && m_axi.bvalid;
    assign ar_hs         = (state == S_RD_ADDR) && m_axi.arready;
    assign r_hs          = (state == S_RD_DATA) && m_axi.rvalid;
    assign at_last_beat  = (beat_cnt == LAST_BEAT);
    assign at_last_burst = (burst_cnt == LAST_BURST);
    assign rd_bad        = (m_axi.rdata != pattern) || (m_axi.rresp != 2'b00);

    // A bad write response is charged to the burst base; a bad read beat to
    // its own byte address. At most one error per beat.
    assign err_event     = (b_hs && (m_axi.bresp != 2'b00)) || (r_hs && rd_bad);
    assign err_addr      = (state == S_RD_DATA) ? beat_addr : base_addr;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and channel control
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        aw_valid   = 1'b0;
        w_valid    = 1'b0;
        w_last     = 1'b0;
        b_ready    = 1'b0;
        ar_valid   = 1'b0;
        r_ready    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_WAIT_CAL;
            end
            S_WAIT_CAL: begin
                if (init_calib_complete) state_next = S_WR_ADDR;
            end
            S_WR_ADDR: begin
                aw_valid = 1'b1;
                if (aw_hs) state_next = S_WR_DATA;
            end
            S_WR_DATA: begin
                w_valid = 1'b1;
                w_last  = at_last_beat;
                if (w_hs && at_last_beat) state_next = S_WR_RESP;
            end
            S_WR_RESP: begin
                b_ready = 1'b1;
                if (b_hs) state_next = at_last_burst ? S_RD_ADDR : S_WR_ADDR;
            end
            S_RD_ADDR: begin
                ar_valid = 1'b1;
                if (ar_hs) state_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                r_ready = 1'b1;
                if (r_hs && m_axi.rlast) state_next = at_last_burst ? S_DONE : S_RD_ADDR;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Burst/beat bookkeeping and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            base_addr <= START_ADDR;
            burst_cnt <= '0;
            beat_cnt  <= '0;
            seed_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seed_q    <= DATA_WIDTH'(seed);
                        base_addr <= START_ADDR;
                        burst_cnt <= '0;
                        beat_cnt  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                S_WR_DATA: begin
                    if (w_hs) beat_cnt <= at_last_beat ? 8'd0 : beat_cnt + 8'd1;
                end
                S_WR_RESP: begin
                    if (b_hs) begin
                        // Rewind to the start address for the read phase.
                        if (at_last_burst) begin
                            base_addr <= START_ADDR;
                            burst_cnt <= '0;
                        end else begin
                            base_addr <= base_addr + BURST_BYTES;
                            burst_cnt <= burst_cnt + BCW'(1);
                        end
                    end
                end
                S_RD_DATA: begin
                    if (r_hs) begin
                        // rlast ends the burst whatever beat it arrives on.
                        if (m_axi.rlast) begin
                            beat_cnt <= 8'd0;
                            if (!at_last_burst) begin
                                base_addr <= base_addr + BURST_BYTES;
                                burst_cnt <= burst_cnt + BCW'(1);
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == 16'd0);
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Error counter (saturating) and first failing address
    // ------------------------------------------------------------------
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            err_count      <= 16'd0;
            first_err_addr <= '0;
        end else if (start_accept) begin
            err_count      <= 16'd0;
            first_err_addr <= '0;
        end else if (err_event) begin
            if (err_count == 16'd0) first_err_addr <= err_addr;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // AXI outputs
    // ------------------------------------------------------------------
    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = base_addr;
    assign m_axi.awlen   = LAST_BEAT;
    assign m_axi.awsize  = 3'b010;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awqos   = 4'h0;
    assign m_axi.awvalid = aw_valid;

    assign m_axi.wdata   = pattern;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = w_last;
    assign m_axi.wvalid  = w_valid;

    assign m_axi.bready  = b_ready;

    assign m_axi.arid    = '0;
    assign m_axi.araddr  = base_addr;
    assign m_axi.arlen   = LAST_BEAT;
    assign m_axi.arsize  = 3'b010;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arqos   = 4'h0;
    assign m_axi.arvalid = ar_valid;

    assign m_axi.rready  = r_ready;

endmodule
`default_nettype wire
